// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter: four requesters share one ALU_FSM, one operation in flight.
// Define ALU_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (sticky err, err_clr).
module alu_issue_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] req_op,
    input  logic [23:0] req_ri,
    input  logic [23:0] req_rj,
    output logic [3:0]  ack,
    output logic        start,
    output logic [3:0]  opCode,
    output logic [5:0]  Ri,
    output logic [5:0]  Rj,
    input  logic        done,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [3:0]  op_q, op_d;
    logic [5:0]  ri_q, ri_d;
    logic [5:0]  rj_q, rj_d;

    logic [3:0]  op_arr [4];
    logic [5:0]  ri_arr [4];
    logic [5:0]  rj_arr [4];
    logic [1:0]  rr_sel;
    logic [1:0]  rr_idx;
    logic        rr_found;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign op_arr[g] = req_op[4*g +: 4];
        assign ri_arr[g] = req_ri[6*g +: 6];
        assign rj_arr[g] = req_rj[6*g +: 6];
    end

`ifdef ALU_ARB_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        timeout_hit;

    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign err         = err_q;
`else
    logic        unused_cfg;

    assign unused_cfg = ^{err_clr, 8'(TIMEOUT_CYCLES)};
    assign err        = 1'b0;
`endif

    // Search starts just after the last acknowledged requester, so it has lowest priority.
    always_comb begin
        rr_sel   = last_grant_q;
        rr_idx   = last_grant_q;
        rr_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_grant_q + 2'(i);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        ri_d         = ri_q;
        rj_d         = rj_q;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_clr ? 1'b0 : err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_id_d = rr_sel;
                    op_d       = op_arr[rr_sel];
                    ri_d       = ri_arr[rr_sel];
                    rj_d       = rj_arr[rr_sel];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (done) begin
                    state_d = ST_ACK;
`ifdef ALU_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            ST_ACK: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= 2'd0;
            last_grant_q <= 2'd3;
            op_q         <= '0;
            ri_q         <= '0;
            rj_q         <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            ri_q         <= ri_d;
            rj_q         <= rj_d;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign start    = (state_q == ST_ISSUE);
    assign busy     = (state_q != ST_IDLE);
    assign ack      = (state_q == ST_ACK) ? (4'b0001 << grant_id_q) : 4'b0000;
    assign grant_id = grant_id_q;
    assign opCode   = op_q;
    assign Ri       = ri_q;
    assign Rj       = rj_q;

endmodule
